// File: rtl/inst_loader.sv
// Program-image loader: streams machine-code words into instruction memory
// from address 0 upward, keeping a running XOR checksum of the image.
module inst_loader #(
  parameter int IW = 10,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [IW-1:0] length,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [IW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          loaded,
  output logic [DW-1:0] checksum
);

  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH, S_DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] cnt_p0, len_p0;
  logic          accept_p0, last_word_p0;
  logic          wr_en_p1;
  logic [IW-1:0] wr_addr_p1;
  logic [DW-1:0] wr_data_p1, checksum_p1;
  logic          loaded_q;

  // Length of 0 wraps len-1 to all-ones, i.e. a full 2**IW-word image
  always_comb begin
    in_ready     = (state == S_LOAD) && !abort;
    accept_p0    = in_valid && in_ready;
    last_word_p0 = (cnt_p0 == (len_p0 - ONE));
    busy         = (state == S_LOAD) || (state == S_FINISH);
    done         = (state == S_DONE);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (abort)                         state_nx = S_IDLE;
        else if (accept_p0 && last_word_p0) state_nx = S_FINISH;
      end
      S_FINISH: state_nx = abort ? S_IDLE : S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // p0 -> p1: accepted word becomes a registered memory write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0      <= '0;
      len_p0      <= '0;
      wr_en_p1    <= 1'b0;
      wr_addr_p1  <= '0;
      wr_data_p1  <= '0;
      checksum_p1 <= '0;
      loaded_q    <= 1'b0;
    end else begin
      wr_en_p1 <= accept_p0;
      if (state == S_IDLE && start) begin
        len_p0      <= length;
        cnt_p0      <= '0;
        checksum_p1 <= '0;
        loaded_q    <= 1'b0;
      end
      if (accept_p0) begin
        wr_addr_p1  <= cnt_p0;
        wr_data_p1  <= in_data;
        checksum_p1 <= checksum_p1 ^ in_data;
        // Counter parks on the final address so it never wraps
        if (!last_word_p0) cnt_p0 <= cnt_p0 + ONE;
      end
      if (state == S_FINISH && !abort) loaded_q <= 1'b1;
    end
  end

  assign wr_en    = wr_en_p1;
  assign wr_addr  = wr_addr_p1;
  assign wr_data  = wr_data_p1;
  assign checksum = checksum_p1;
  assign loaded   = loaded_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: drives on negedge+1, logs writes at negedge.
module tb_inst_loader;

  localparam int IW = 10;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] length = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr_en, busy, done, loaded;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data, checksum;

  int checks = 0;
  int failures = 0;

  int log_addr [0:4095];
  int log_data [0:4095];
  int log_cyc  [0:4095];
  int log_n = 0;
  int done_cnt = 0;
  int cyc = 0;

  inst_loader #(.IW(IW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .loaded(loaded), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en) begin
      log_addr[log_n] = int'(wr_addr);
      log_data[log_n] = int'(wr_data);
      log_cyc[log_n]  = cyc;
      log_n = log_n + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    start  = 1'b1;
    length = IW'(len);
    step();
    start = 1'b0;
    check("start_in_ready", int'(in_ready), 1);
    check("start_busy", int'(busy), 1);
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = DW'(d);
    step();
    in_valid = 1'b0;
  endtask

  int base, dbase, errs;
  int words [4];

  initial begin
    // Reset state
    #3;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_loaded", int'(loaded), 0);
    check("rst_checksum", int'(checksum), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_in_ready", int'(in_ready), 0);

    // Basic back-to-back load of 4 words
    words = '{32'h001, 32'h0A5, 32'h1FF, 32'h100};
    base = log_n; dbase = done_cnt;
    start_load(4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(words[i]); step();
    end
    in_valid = 1'b0;
    check("basic_finish_busy", int'(busy), 1);
    check("basic_finish_ready", int'(in_ready), 0);
    check("basic_finish_wren", int'(wr_en), 1);
    check("basic_finish_addr", int'(wr_addr), 3);
    check("basic_finish_done", int'(done), 0);
    step();
    check("basic_done", int'(done), 1);
    check("basic_loaded", int'(loaded), 1);
    check("basic_checksum", int'(checksum), 'h05B);
    step();
    check("basic_done_pulse", int'(done), 0);
    check("basic_idle_busy", int'(busy), 0);
    check("basic_loaded_hold", int'(loaded), 1);
    check("basic_nwrites", log_n - base, 4);
    for (int i = 0; i < 4; i++) begin
      check("basic_addr", log_addr[base+i], i);
      check("basic_data", log_data[base+i], words[i]);
      if (i > 0) check("basic_b2b", log_cyc[base+i] - log_cyc[base+i-1], 1);
    end
    check("basic_done_cnt", done_cnt - dbase, 1);

    // Gapped stream: valid 1,0,1,0,1
    base = log_n;
    start_load(3);
    send('h011); step();
    send('h022); step();
    send('h044);
    check("gap_finish_addr", int'(wr_addr), 2);
    step();
    check("gap_done", int'(done), 1);
    check("gap_checksum", int'(checksum), 'h077);
    step(); step();
    check("gap_nwrites", log_n - base, 3);
    check("gap_addr0", log_addr[base], 0);
    check("gap_data2", log_data[base+2], 'h044);
    check("gap_spacing", log_cyc[base+1] - log_cyc[base], 2);
    check("gap_spacing2", log_cyc[base+2] - log_cyc[base+1], 2);

    // Full image with Length=0
    base = log_n; dbase = done_cnt;
    start_load(0);
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_data = DW'(i); step();
      if (i < 1023 && !busy) begin
        check("full_early_exit", i, 1023);
        break;
      end
    end
    in_valid = 1'b0;
    check("full_last_addr", int'(wr_addr), 1023);
    check("full_last_data", int'(wr_data), 'h1FF);
    step();
    check("full_done", int'(done), 1);
    check("full_checksum", int'(checksum), 0);
    step(); step(); step();
    check("full_nwrites", log_n - base, 1024);
    errs = 0;
    for (int i = 0; i < 1024; i++)
      if (log_addr[base+i] != i || log_data[base+i] != (i % 512)) errs++;
    check("full_seq_errs", errs, 0);
    check("full_done_cnt", done_cnt - dbase, 1);

    // Abort after 3 accepts
    base = log_n; dbase = done_cnt;
    start_load(8);
    check("abort_loaded_clr", int'(loaded), 0);
    send('h0AA); send('h0BB); send('h0CC);
    abort = 1'b1; in_valid = 1'b1; in_data = 'h0DD;
    #1;
    check("abort_in_ready", int'(in_ready), 0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_idle_busy", int'(busy), 0);
    step(); step(); step();
    check("abort_nwrites", log_n - base, 3);
    check("abort_last_addr", log_addr[base+2], 2);
    check("abort_done_cnt", done_cnt - dbase, 0);
    check("abort_loaded", int'(loaded), 0);
    check("abort_checksum", int'(checksum), 'h0DD);
    base = log_n;
    start_load(2);
    send('h123); send('h045);
    step();
    check("reload_done", int'(done), 1);
    check("reload_loaded", int'(loaded), 1);
    step();
    check("reload_nwrites", log_n - base, 2);
    check("reload_addr1", log_addr[base+1], 1);
    check("reload_data1", log_data[base+1], 'h045);

    // Asynchronous reset mid-load
    start_load(5);
    send('h155); send('h0AA);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", int'(wr_en), 0);
    check("arst_wr_addr", int'(wr_addr), 0);
    check("arst_wr_data", int'(wr_data), 0);
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_loaded", int'(loaded), 0);
    check("arst_checksum", int'(checksum), 0);
    step();
    rst_n = 1'b1;
    step();
    base = log_n;
    start_load(1);
    send('h1A5);
    step();
    check("post_rst_done", int'(done), 1);
    step();
    check("post_rst_nwrites", log_n - base, 1);
    check("post_rst_addr", log_addr[base], 0);
    check("post_rst_data", log_data[base], 'h1A5);

    // Start ignored during LOAD
    base = log_n;
    start_load(3);
    send('h001);
    start = 1'b1; length = 7;
    send('h002);
    start = 1'b0;
    send('h003);
    check("ign_finish_busy", int'(busy), 1);
    check("ign_finish_ready", int'(in_ready), 0);
    check("ign_finish_addr", int'(wr_addr), 2);
    step();
    check("ign_done", int'(done), 1);
    step();
    check("ign_nwrites", log_n - base, 3);

    // Abort coincident with last accept
    base = log_n; dbase = done_cnt;
    start_load(2);
    send('h0F0);
    abort = 1'b1; in_valid = 1'b1; in_data = 'h00F;
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("coinc_busy", int'(busy), 0);
    check("coinc_wr_en", int'(wr_en), 0);
    step(); step(); step();
    check("coinc_nwrites", log_n - base, 1);
    check("coinc_done_cnt", done_cnt - dbase, 0);
    check("coinc_loaded", int'(loaded), 0);
    check("coinc_checksum", int'(checksum), 'h0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
